// File: rtl/fpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_ctrl_pkg
//  Purpose  : Shared types and constants for the FP add/sub issue controller.
//             Holds the controller state encoding and the datapath opcodes
//             that are driven on dp_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
package fpu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } fpu_state_e;

  // Datapath opcodes; only bit 0 (subtract) is ever non-zero.
  localparam logic [4:0] FOP_ADD = 5'b00000;
  localparam logic [4:0] FOP_SUB = 5'b00001;

endpackage
`default_nettype wire

// File: rtl/fpu_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_rr_arbiter
//  Purpose  : NREQ-wide round-robin arbiter. The grant is combinational from
//             req; the priority pointer moves to one past the granted index
//             only when the grant is actually taken (advance).
//  Ports    : clk, rst_n    - clock / async active-low reset
//             req          - request vector
//             advance      - grant is consumed this cycle
//             grant        - one-hot grant (zero when no request)
//             grant_idx    - binary index of the granted requester
//             any          - at least one request is present
//  Revision : 1.0 - initial release
// ============================================================================
import fpu_ctrl_pkg::*;

module fpu_rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             advance,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] r_ptr;
  int               w_cand;

  // Search upward from the pointer with wrap; first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    w_cand    = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = int'(r_ptr) + i;
      if (w_cand >= NREQ) w_cand = w_cand - NREQ;
      if (!any && req[w_cand]) begin
        any           = 1'b1;
        grant_idx     = IDX_W'(w_cand);
        grant[w_cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance && any) begin
      r_ptr <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_addsub_sched.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_addsub_sched
//  Purpose  : Round-robin issue controller sharing one combinational FP
//             add/sub unit between NREQ requesters. Operands are held in
//             registers for EXEC_CYCLES so the unit can be constrained as a
//             multicycle path; the result is returned with requester id and
//             tag over a valid/ready response port.
//  Ports    : clk, rst_n          - clock / async active-low reset
//             flush               - drop in-flight op and pending response
//             req_valid/ready     - per-requester handshake
//             req_sub/a/b/tag     - per-requester operation (packed by index)
//             dp_ctrl/in1/in2     - registered drive to the datapath
//             dp_out              - combinational datapath result
//             rsp_valid/ready     - response handshake
//             rsp_id/tag/data     - owner index, tag and result
//             busy                - controller not idle
//  Revision : 1.0 - initial release
// ============================================================================
import fpu_ctrl_pkg::*;

module fpu_addsub_sched #(
  parameter int NREQ        = 2,
  parameter int TAG_W       = 4,
  parameter int EXEC_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_sub,
  input  logic [NREQ*32-1:0]      req_a,
  input  logic [NREQ*32-1:0]      req_b,
  input  logic [NREQ*TAG_W-1:0]   req_tag,
  output logic [4:0]              dp_ctrl,
  output logic [31:0]             dp_in1,
  output logic [31:0]             dp_in2,
  input  logic [31:0]             dp_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic [31:0]             rsp_data,
  output logic                    busy
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  fpu_state_e       r_state;
  fpu_state_e       w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sub;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [TAG_W-1:0] r_tag;
  logic [ID_W-1:0]  r_gid;
  logic [31:0]      r_result;
  logic [ID_W-1:0]  r_rsp_id;
  logic [TAG_W-1:0] r_rsp_tag;

  logic             w_can_accept;
  logic             w_hs;
  logic [NREQ-1:0]  w_grant;
  logic [ID_W-1:0]  w_gidx;
  logic             w_any;

  // A new op may only be taken when the unit is free: idle, or the pending
  // response is being popped this very cycle (back-to-back issue).
  assign w_can_accept = !flush &&
                        ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready));
  assign w_hs         = w_can_accept && w_any;
  assign req_ready    = w_grant & {NREQ{w_can_accept}};

  fpu_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (w_can_accept),
    .grant     (w_grant),
    .grant_idx (w_gidx),
    .any       (w_any)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_state_nx = S_EXEC;
      S_EXEC:  if (r_cnt == '0) w_state_nx = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nx = w_hs ? S_EXEC : S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    if (flush) w_state_nx = S_IDLE;
  end

  // ------------------------------------------------- operands and result
  // Operand registers are the only source of dp_*, so the datapath inputs
  // cannot move while an op is executing or its response is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_sub     <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_tag     <= '0;
      r_gid     <= '0;
      r_result  <= '0;
      r_rsp_id  <= '0;
      r_rsp_tag <= '0;
    end else if (w_hs) begin
      r_sub <= req_sub[w_gidx];
      r_a   <= req_a[32*int'(w_gidx) +: 32];
      r_b   <= req_b[32*int'(w_gidx) +: 32];
      r_tag <= req_tag[TAG_W*int'(w_gidx) +: TAG_W];
      r_gid <= w_gidx;
      r_cnt <= CNT_W'(EXEC_CYCLES - 1);
    end else if (!flush && (r_state == S_EXEC)) begin
      if (r_cnt == '0) begin
        r_result  <= dp_out;
        r_rsp_id  <= r_gid;
        r_rsp_tag <= r_tag;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // ------------------------------------------------------------ outputs
  assign dp_ctrl   = r_sub ? FOP_SUB : FOP_ADD;
  assign dp_in1    = r_a;
  assign dp_in2    = r_b;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_tag   = r_rsp_tag;
  assign rsp_data  = r_result;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu_addsub_sched
//  Purpose  : Directed self-checking bench for fpu_addsub_sched. The FP unit
//             is stood in by a lookup of the operand pairs used below, with
//             an obviously wrong value for anything else.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_addsub_sched;

  localparam int NREQ  = 2;
  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_sub;
  logic [63:0]       req_a;
  logic [63:0]       req_b;
  logic [7:0]        req_tag;
  logic [4:0]        dp_ctrl;
  logic [31:0]       dp_in1;
  logic [31:0]       dp_in2;
  logic [31:0]       dp_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [0:0]        rsp_id;
  logic [3:0]        rsp_tag;
  logic [31:0]       rsp_data;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fpu_addsub_sched #(.NREQ(NREQ), .TAG_W(TAG_W), .EXEC_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .dp_ctrl(dp_ctrl), .dp_in1(dp_in1), .dp_in2(dp_in2), .dp_out(dp_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_data(rsp_data), .busy(busy)
  );

  // Stand-in FP add/sub unit: hand-computed IEEE754 results.
  always_comb begin
    case ({dp_ctrl, dp_in1, dp_in2})
      {5'b00000, 32'h3F800000, 32'h40000000}: dp_out = 32'h40400000; // 1+2
      {5'b00001, 32'h40400000, 32'h3F800000}: dp_out = 32'h40000000; // 3-1
      {5'b00000, 32'h3F800000, 32'h3F800000}: dp_out = 32'h40000000; // 1+1
      {5'b00000, 32'h40000000, 32'h40000000}: dp_out = 32'h40800000; // 2+2
      {5'b00001, 32'h40800000, 32'h40000000}: dp_out = 32'h40000000; // 4-2
      {5'b00001, 32'h40A00000, 32'h3F800000}: dp_out = 32'h40800000; // 5-1
      default:                                dp_out = 32'hDEADBEEF;
    endcase
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic set_req(input int i, input logic v, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t);
    req_valid[i]       = v;
    req_sub[i]         = s;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
    req_tag[4*i +: 4]  = t;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
  endtask

  task automatic pulse_reset();
    clear_reqs();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
    req_valid = '0; req_sub = '0; req_a = '0; req_b = '0; req_tag = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %h exp 0", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %h exp 0", busy); end
    n_checks++; if ({dp_ctrl, dp_in1, dp_in2} !== 69'd0) begin n_fail++; $display("FAIL reset_dp got %h %h %h exp 0", dp_ctrl, dp_in1, dp_in2); end
    n_checks++; if ({rsp_id, rsp_tag, rsp_data} !== 37'd0) begin n_fail++; $display("FAIL reset_rsp got %h %h %h exp 0", rsp_id, rsp_tag, rsp_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    set_req(0, 1'b1, 1'b0, 32'h3F800000, 32'h40000000, 4'd3);
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL add_req_ready got %b exp 01", req_ready); end
    @(negedge clk); clear_reqs();
    n_checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_exec1 busy %h rsp_valid %h exp 1 0", busy, rsp_valid); end
    n_checks++; if (dp_in1 !== 32'h3F800000 || dp_in2 !== 32'h40000000 || dp_ctrl !== 5'b00000) begin n_fail++; $display("FAIL add_dp got %h %h %h", dp_ctrl, dp_in1, dp_in2); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_exec2_rsp_valid got %h exp 0", rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h40400000 || rsp_id !== 1'b0 || rsp_tag !== 4'd3) begin
      n_fail++; $display("FAIL add_rsp got v%h d%h id%h t%h exp v1 d40400000 id0 t3", rsp_valid, rsp_data, rsp_id, rsp_tag); end
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL add_pop got v%h busy%h exp 0 0", rsp_valid, busy); end
  endtask

  task automatic test_sub();
    set_req(1, 1'b1, 1'b1, 32'h40400000, 32'h3F800000, 4'd5);
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL sub_req_ready got %b exp 10", req_ready); end
    @(negedge clk); clear_reqs();
    n_checks++; if (dp_ctrl !== 5'b00001) begin n_fail++; $display("FAIL sub_ctrl_exec1 got %b exp 00001", dp_ctrl); end
    @(negedge clk);
    n_checks++; if (dp_ctrl !== 5'b00001) begin n_fail++; $display("FAIL sub_ctrl_exec2 got %b exp 00001", dp_ctrl); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h40000000 || rsp_id !== 1'b1 || rsp_tag !== 4'd5) begin
      n_fail++; $display("FAIL sub_rsp got v%h d%h id%h t%h exp v1 d40000000 id1 t5", rsp_valid, rsp_data, rsp_id, rsp_tag); end
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_contention();
    logic [31:0] exp_d;
    pulse_reset();
    set_req(0, 1'b1, 1'b0, 32'h40000000, 32'h40000000, 4'd1);
    set_req(1, 1'b1, 1'b1, 32'h40800000, 32'h40000000, 4'd2);
    rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      n_checks++; if (req_ready !== ((n % 2 == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL cont_grant%0d got %b", n, req_ready); end
      if (n > 0) begin
        exp_d = ((n - 1) % 2 == 0) ? 32'h40800000 : 32'h40000000;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'((n - 1) % 2) || rsp_data !== exp_d) begin
          n_fail++; $display("FAIL cont_rsp%0d got v%h id%h d%h exp v1 id%0d d%h", n, rsp_valid, rsp_id, rsp_data, (n - 1) % 2, exp_d); end
      end
      repeat (3) @(negedge clk);
    end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'h40000000 || rsp_tag !== 4'd2) begin
      n_fail++; $display("FAIL cont_last got v%h id%h d%h t%h exp v1 id1 d40000000 t2", rsp_valid, rsp_id, rsp_data, rsp_tag); end
    clear_reqs();
    @(negedge clk); rsp_ready = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_idle busy got %h exp 0", busy); end
  endtask

  task automatic test_backpressure();
    set_req(0, 1'b1, 1'b1, 32'h40A00000, 32'h3F800000, 4'd7);
    @(negedge clk); clear_reqs();
    repeat (2) @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'h3F800000, 32'h3F800000, 4'd9);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h40800000 || rsp_tag !== 4'd7 || rsp_id !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d got v%h d%h t%h id%h", k, rsp_valid, rsp_data, rsp_tag, rsp_id); end
      n_checks++; if (req_ready !== 2'b00 || dp_in1 !== 32'h40A00000 || dp_ctrl !== 5'b00001) begin
        n_fail++; $display("FAIL bp_stall%0d got rdy%b in1 %h ctrl %b", k, req_ready, dp_in1, dp_ctrl); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b01 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_pop got rdy%b v%h exp 01 1", req_ready, rsp_valid); end
    @(negedge clk); clear_reqs(); rsp_ready = 1'b0;
    n_checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || dp_in1 !== 32'h3F800000 || dp_ctrl !== 5'b00000) begin
      n_fail++; $display("FAIL bp_b2b got busy%h v%h in1 %h ctrl %b", busy, rsp_valid, dp_in1, dp_ctrl); end
    repeat (2) @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h40000000 || rsp_tag !== 4'd9) begin
      n_fail++; $display("FAIL bp_second got v%h d%h t%h exp v1 d40000000 t9", rsp_valid, rsp_data, rsp_tag); end
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_flush();
    set_req(1, 1'b1, 1'b0, 32'h3F800000, 32'h40000000, 4'd4);
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL fl_req_ready got %b exp 10", req_ready); end
    @(negedge clk); clear_reqs(); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || dp_in1 !== 32'h3F800000) begin
      n_fail++; $display("FAIL fl_idle got busy%h v%h in1 %h exp 0 0 3f800000", busy, rsp_valid, dp_in1); end
    repeat (2) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fl_no_rsp got %h exp 0", rsp_valid); end
    end
    set_req(0, 1'b1, 1'b1, 32'h40400000, 32'h3F800000, 4'd6);
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL fl_next_ready got %b exp 01", req_ready); end
    @(negedge clk); clear_reqs();
    repeat (2) @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h40000000 || rsp_id !== 1'b0 || rsp_tag !== 4'd6) begin
      n_fail++; $display("FAIL fl_next_rsp got v%h d%h id%h t%h exp v1 d40000000 id0 t6", rsp_valid, rsp_data, rsp_id, rsp_tag); end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fl_resp_drop got v%h busy%h exp 0 0", rsp_valid, busy); end
  endtask

  task automatic test_async_reset();
    set_req(1, 1'b1, 1'b0, 32'h3F800000, 32'h40000000, 4'd3);
    @(negedge clk); clear_reqs();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || {dp_ctrl, dp_in1, dp_in2} !== 69'd0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL arst_exec got busy%h ctrl%b in1 %h in2 %h v%h", busy, dp_ctrl, dp_in1, dp_in2, rsp_valid); end
    @(negedge clk); rst_n = 1'b1;
    set_req(1, 1'b1, 1'b0, 32'h3F800000, 32'h40000000, 4'd8);
    @(negedge clk); clear_reqs();
    repeat (2) @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'h40400000) begin
      n_fail++; $display("FAIL arst_pre got v%h id%h d%h exp v1 id1 d40400000", rsp_valid, rsp_id, rsp_data); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || {rsp_id, rsp_tag, rsp_data} !== 37'd0 || dp_in1 !== 32'd0) begin
      n_fail++; $display("FAIL arst_resp got v%h busy%h id%h t%h d%h in1 %h", rsp_valid, busy, rsp_id, rsp_tag, rsp_data, dp_in1); end
    @(negedge clk); rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h3F800000, 32'h3F800000, 4'hA);
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL arst_ready got %b exp 01", req_ready); end
    @(negedge clk); clear_reqs();
    repeat (2) @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h40000000 || rsp_id !== 1'b0 || rsp_tag !== 4'hA) begin
      n_fail++; $display("FAIL arst_after got v%h d%h id%h t%h exp v1 d40000000 id0 ta", rsp_valid, rsp_data, rsp_id, rsp_tag); end
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_add();
    test_sub();
    test_contention();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
